messbauer_diff_discriminator_receiver: RTL and testbench
========================================================

// Module: messbauer_diff_discriminator_receiver
// PURPOSE
//  Receive side of the differential-discriminator interface: decode lower/upper threshold
//  pulse pairs into accepted (window) and rejected (over-threshold) counts per channel.
//  Sits between the discriminator outputs and the spectrum memory writer.
//  The channel input marks channel boundaries; each boundary emits one count snapshot.
// PARAMETERS
//  COUNT_WIDTH        16   width of accepted/rejected counters (saturating)
//  CHANNEL_WIDTH      12   width of channel_number (wraps)
//  SYNC_STAGES        2    synchronizer flops on lower/upper/channel inputs (>=2)
//  MIN_LOWER_DURATION 2    min lower-high width (aclk cycles) for a valid pulse
//  MAX_LOWER_DURATION 255  lower-high width (cycles) at which a pulse is declared stuck
// PORTS
//  aclk            in   1              clock
//  areset_n        in   1              reset, synchronous, active-low
//  lower_threshold in   1              async lower-threshold discriminator pulse
//  upper_threshold in   1              async upper-threshold discriminator pulse
//  channel         in   1              async channel-advance level; rising edge = boundary
//  accepted_count  out  COUNT_WIDTH    snapshot: pulses over lower, never over upper
//  rejected_count  out  COUNT_WIDTH    snapshot: pulses that also crossed upper
//  count_valid     out  1              1-cycle strobe, snapshot outputs valid
//  channel_number  out  CHANNEL_WIDTH  index of channel the snapshot belongs to
//  protocol_error  out  1              sticky error flag, cleared at each boundary
// BEHAVIOUR
//  Reset: all outputs 0, live counters 0, sync flops 0, width_cnt 0, FSM IDLE.
//  Inputs pass SYNC_STAGES flops, then 1 edge-detect register (lo_s, up_s, ch_s + prev).
//  FSM (on synchronized signals):
//   IDLE: lo_s rise -> LOWER_ACTIVE, width_cnt=1; up_s high while lo_s low -> error, stay.
//   LOWER_ACTIVE: width_cnt++ (saturating); up_s high -> UPPER_SEEN;
//     lo_s fall: width_cnt>=MIN -> accepted++, else error (glitch, no count); -> IDLE.
//   UPPER_SEEN: width_cnt++; lo_s fall -> rejected++ (MIN check as above) -> IDLE.
//   LOWER_ACTIVE/UPPER_SEEN: width_cnt==MAX -> error, -> STUCK (no count).
//   STUCK: wait lo_s low -> IDLE.
//  up_s and lo_s fall in same cycle in LOWER_ACTIVE: counts as rejected.
//  Counters saturate at all-ones; never wrap.
//  Boundary (ch_s rise): next cycle count_valid=1, accepted/rejected_count = live values
//   incl. any pulse classified in the boundary cycle, channel_number = current index,
//   protocol_error = sticky flag incl. errors raised that cycle; then live counters and
//   sticky flag clear, index++ (wraps 2^CHANNEL_WIDTH-1 -> 0).
//  Pulse in flight at a boundary is not cut: it is counted in the channel where lo_s falls.
//  Outputs hold between strobes. Latency lo fall (pin) -> counted: SYNC_STAGES+2 cycles.
//  Reset asserted mid-pulse or mid-channel: all state discarded, no strobe emitted.
// TESTING
//  3 lower pulses width 3, no upper, channel rise -> count_valid, accepted=3, rejected=0,
//   channel_number=0, protocol_error=0.
//  lower width 4 with upper 1 cycle inside, x2, plus 1 clean pulse, boundary -> accepted=1,
//   rejected=2.
//  lower width 1 (< MIN), boundary -> accepted=0, protocol_error=1; next channel error=0.
//  lower held 300 cycles, release, boundary -> accepted=0, rejected=0, protocol_error=1.
//  COUNT_WIDTH=4, 20 clean pulses, boundary -> accepted=15; 4097 boundaries -> channel_number
//   wraps to 0 then 1.
//  areset_n low mid-pulse after 2 accepted -> outputs 0, next boundary snapshot accepted=0.

Source files
------------

// File: rtl/messbauer_diff_discriminator_receiver.sv
// Differential-discriminator receiver: classifies lower/upper threshold pulse pairs into
// per-channel accepted/rejected counts and emits one snapshot per channel boundary.
module messbauer_diff_discriminator_receiver #(
   parameter int unsigned COUNT_WIDTH        = 16,
   parameter int unsigned CHANNEL_WIDTH      = 12,
   parameter int unsigned SYNC_STAGES        = 2,
   parameter int unsigned MIN_LOWER_DURATION = 2,
   parameter int unsigned MAX_LOWER_DURATION = 255
) (
   input  logic                     aclk,
   input  logic                     areset_n,
   input  logic                     lower_threshold,
   input  logic                     upper_threshold,
   input  logic                     channel,
   output logic [COUNT_WIDTH-1:0]   accepted_count,
   output logic [COUNT_WIDTH-1:0]   rejected_count,
   output logic                     count_valid,
   output logic [CHANNEL_WIDTH-1:0] channel_number,
   output logic                     protocol_error
);

   localparam int unsigned WW = $clog2(MAX_LOWER_DURATION + 1);
   localparam logic [WW-1:0] MIN_W = WW'(MIN_LOWER_DURATION);
   localparam logic [WW-1:0] MAX_W = WW'(MAX_LOWER_DURATION);

   localparam logic [1:0] ST_IDLE         = 2'd0;
   localparam logic [1:0] ST_LOWER_ACTIVE = 2'd1;
   localparam logic [1:0] ST_UPPER_SEEN   = 2'd2;
   localparam logic [1:0] ST_STUCK        = 2'd3;

   logic [SYNC_STAGES-1:0]   lo_sync, up_sync, ch_sync;
   logic                     lo_s, up_s, ch_s, lo_prev, ch_prev;
   logic                     ch_rise;
   logic [1:0]               state, state_nxt;
   logic [WW-1:0]            width_cnt, width_nxt;
   logic                     acc_inc, rej_inc, err_set;
   logic [COUNT_WIDTH-1:0]   acc_live, rej_live, acc_next, rej_next;
   logic                     err_live, err_next;
   logic [CHANNEL_WIDTH-1:0] chan_idx;

   assign ch_rise = ch_s & ~ch_prev;

   always_comb begin
      state_nxt = state;
      width_nxt = width_cnt;
      acc_inc   = 1'b0;
      rej_inc   = 1'b0;
      err_set   = 1'b0;
      case (state)
         ST_IDLE: begin
            if (lo_s && !lo_prev) begin
               state_nxt = ST_LOWER_ACTIVE;
               width_nxt = WW'(1);
            end else if (up_s && !lo_s) begin
               err_set = 1'b1;
            end
         end
         ST_LOWER_ACTIVE, ST_UPPER_SEEN: begin
            if (width_cnt == MAX_W) begin
               err_set   = 1'b1;
               state_nxt = ST_STUCK;
            end else if (!lo_s) begin
               // upper arriving together with the lower fall still marks the pulse as rejected
               if (width_cnt >= MIN_W) begin
                  if (state == ST_UPPER_SEEN || up_s) rej_inc = 1'b1;
                  else                                acc_inc = 1'b1;
               end else begin
                  err_set = 1'b1;
               end
               state_nxt = ST_IDLE;
            end else begin
               if (width_cnt != '1) width_nxt = width_cnt + 1'b1;
               if (up_s) state_nxt = ST_UPPER_SEEN;
            end
         end
         ST_STUCK: begin
            if (!lo_s) state_nxt = ST_IDLE;
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   always_comb begin
      acc_next = (acc_inc && acc_live != '1) ? acc_live + 1'b1 : acc_live;
      rej_next = (rej_inc && rej_live != '1) ? rej_live + 1'b1 : rej_live;
      err_next = err_live | err_set;
   end

   always_ff @(posedge aclk) begin
      if (!areset_n) begin
         lo_sync        <= '0;
         up_sync        <= '0;
         ch_sync        <= '0;
         lo_s           <= 1'b0;
         up_s           <= 1'b0;
         ch_s           <= 1'b0;
         lo_prev        <= 1'b0;
         ch_prev        <= 1'b0;
         state          <= ST_IDLE;
         width_cnt      <= '0;
         acc_live       <= '0;
         rej_live       <= '0;
         err_live       <= 1'b0;
         chan_idx       <= '0;
         accepted_count <= '0;
         rejected_count <= '0;
         count_valid    <= 1'b0;
         channel_number <= '0;
         protocol_error <= 1'b0;
      end else begin
         lo_sync   <= {lo_sync[SYNC_STAGES-2:0], lower_threshold};
         up_sync   <= {up_sync[SYNC_STAGES-2:0], upper_threshold};
         ch_sync   <= {ch_sync[SYNC_STAGES-2:0], channel};
         lo_s      <= lo_sync[SYNC_STAGES-1];
         up_s      <= up_sync[SYNC_STAGES-1];
         ch_s      <= ch_sync[SYNC_STAGES-1];
         lo_prev   <= lo_s;
         ch_prev   <= ch_s;
         state     <= state_nxt;
         width_cnt <= width_nxt;
         count_valid <= ch_rise;
         // the snapshot takes the next-state counters so a pulse closing on the boundary cycle lands in it
         if (ch_rise) begin
            accepted_count <= acc_next;
            rejected_count <= rej_next;
            protocol_error <= err_next;
            channel_number <= chan_idx;
            chan_idx       <= chan_idx + 1'b1;
            acc_live       <= '0;
            rej_live       <= '0;
            err_live       <= 1'b0;
         end else begin
            acc_live <= acc_next;
            rej_live <= rej_next;
            err_live <= err_next;
         end
      end
   end

endmodule

// File: tb/tb_messbauer_diff_discriminator_receiver.sv
// Bench for messbauer_diff_discriminator_receiver: pulse-level reference model, per-cycle
// output compare on a 16-bit and a 4-bit counter instance driven by the same stimulus.
module tb_messbauer_diff_discriminator_receiver;

   localparam int unsigned SYNC  = 2;
   localparam int unsigned MIN_W = 2;
   localparam int unsigned MAX_W = 255;

   logic aclk = 1'b0;
   logic areset_n = 1'b0;
   logic lower_threshold = 1'b0;
   logic upper_threshold = 1'b0;
   logic channel = 1'b0;

   logic [15:0] acc16, rej16;
   logic [3:0]  acc4, rej4;
   logic [11:0] ch16, ch4;
   logic        v16, v4, e16, e4;
   logic [65:0] dut_vec;

   always #5 aclk = ~aclk;

   messbauer_diff_discriminator_receiver #(
      .COUNT_WIDTH(16), .CHANNEL_WIDTH(12), .SYNC_STAGES(SYNC),
      .MIN_LOWER_DURATION(MIN_W), .MAX_LOWER_DURATION(MAX_W)
   ) dut16 (
      .aclk(aclk), .areset_n(areset_n), .lower_threshold(lower_threshold),
      .upper_threshold(upper_threshold), .channel(channel),
      .accepted_count(acc16), .rejected_count(rej16), .count_valid(v16),
      .channel_number(ch16), .protocol_error(e16)
   );

   messbauer_diff_discriminator_receiver #(
      .COUNT_WIDTH(4), .CHANNEL_WIDTH(12), .SYNC_STAGES(SYNC),
      .MIN_LOWER_DURATION(MIN_W), .MAX_LOWER_DURATION(MAX_W)
   ) dut4 (
      .aclk(aclk), .areset_n(areset_n), .lower_threshold(lower_threshold),
      .upper_threshold(upper_threshold), .channel(channel),
      .accepted_count(acc4), .rejected_count(rej4), .count_valid(v4),
      .channel_number(ch4), .protocol_error(e4)
   );

   assign dut_vec = {acc16, rej16, acc4, rej4, ch16, ch4, e16, e4};

   typedef struct {
      int unsigned acc;
      int unsigned rej;
      bit          err;
      int unsigned ch;
      longint      due;
   } snap_t;

   snap_t       expq[$];
   snap_t       last;
   longint      cyc = 0;
   bit          in_reset = 1'b1;
   int unsigned m_acc, m_rej, m_idx;
   bit          m_err;
   int          errors = 0;
   int          checks = 0;

   always @(posedge aclk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, exp);
      end
   endtask

   function automatic logic [15:0] sat16(input int unsigned v);
      return (v > 65535) ? 16'hFFFF : v[15:0];
   endfunction

   function automatic logic [3:0] sat4(input int unsigned v);
      return (v > 15) ? 4'hF : v[3:0];
   endfunction

   function automatic logic [65:0] exp_vec(input snap_t s);
      return {sat16(s.acc), sat16(s.rej), sat4(s.acc), sat4(s.rej), s.ch[11:0], s.ch[11:0], s.err, s.err};
   endfunction

   // Reference: a closed pulse is judged purely by its width and whether upper showed up.
   task automatic classify(input int unsigned w, input bit had_upper);
      if (w < MIN_W || w >= MAX_W) m_err = 1'b1;
      else if (had_upper)          m_rej++;
      else                         m_acc++;
   endtask

   task automatic push_boundary();
      snap_t s;
      s.acc = m_acc;
      s.rej = m_rej;
      s.err = m_err;
      s.ch  = m_idx % 4096;
      s.due = cyc + SYNC + 2;
      expq.push_back(s);
      m_acc = 0;
      m_rej = 0;
      m_err = 1'b0;
      m_idx++;
   endtask

   always @(negedge aclk) begin
      bit exp_v;
      if (!in_reset) begin
         exp_v = 1'b0;
         if (expq.size() != 0) begin
            if (expq[0].due == cyc) exp_v = 1'b1;
         end
         chk("count_valid", {v16, v4}, exp_v ? 2'b11 : 2'b00);
         if (exp_v) last = expq.pop_front();
         chk("snapshot", dut_vec, exp_vec(last));
      end
   end

   task automatic drive_pulse(input int unsigned w, input int unsigned uo,
                              input int unsigned ul, input int unsigned gap);
      for (int unsigned i = 0; i <= w; i++) begin
         @(negedge aclk);
         lower_threshold = (i < w);
         upper_threshold = (ul > 0) && (i >= uo) && (i < uo + ul);
      end
      classify(w, ul > 0);
      repeat (gap) begin
         @(negedge aclk);
         lower_threshold = 1'b0;
         upper_threshold = 1'b0;
      end
   endtask

   task automatic stray_upper();
      @(negedge aclk) upper_threshold = 1'b1;
      @(negedge aclk);
      @(negedge aclk) upper_threshold = 1'b0;
      m_err = 1'b1;
      repeat (4) @(negedge aclk);
   endtask

   task automatic boundary();
      @(negedge aclk);
      channel = 1'b1;
      push_boundary();
      repeat (2) @(negedge aclk);
      channel = 1'b0;
      repeat (2) @(negedge aclk);
   endtask

   task automatic wait_drain();
      for (int i = 0; i < 64 && expq.size() != 0; i++) @(negedge aclk);
      chk("drain_timeout", expq.size(), 0);
      repeat (2) @(negedge aclk);
   endtask

   task automatic expect_lit(input string name, input int unsigned a16, input int unsigned r16,
                             input int unsigned a4, input bit err, input int unsigned ch);
      chk({name, "_accepted"}, acc16, a16);
      chk({name, "_rejected"}, rej16, r16);
      chk({name, "_accepted_w4"}, acc4, a4);
      chk({name, "_error"}, e16, err);
      chk({name, "_channel"}, ch16, ch);
   endtask

   task automatic do_reset(input int unsigned hold_lower_cycles);
      @(negedge aclk);
      in_reset = 1'b1;
      areset_n = 1'b0;
      expq.delete();
      m_acc = 0;
      m_rej = 0;
      m_err = 1'b0;
      m_idx = 0;
      last  = '{default: 0};
      repeat (hold_lower_cycles) @(negedge aclk);
      lower_threshold = 1'b0;
      upper_threshold = 1'b0;
      channel         = 1'b0;
      repeat (3) @(negedge aclk);
      chk("reset_outputs", dut_vec, 66'd0);
      chk("reset_valid", {v16, v4}, 2'b00);
      areset_n = 1'b1;
      in_reset = 1'b0;
   endtask

   initial begin
      #3_000_000;
      $display("FAIL watchdog: simulation did not complete in time");
      $fatal(1, "watchdog");
   end

   initial begin
      int unsigned np, w, kind;
      m_acc = 0; m_rej = 0; m_err = 1'b0; m_idx = 0;
      last = '{default: 0};
      do_reset(0);

      repeat (3) drive_pulse(3, 0, 0, 4);
      boundary(); wait_drain();
      expect_lit("clean3", 3, 0, 3, 1'b0, 0);

      repeat (2) drive_pulse(4, 2, 1, 4);
      drive_pulse(4, 0, 0, 4);
      boundary(); wait_drain();
      expect_lit("upper_mix", 1, 2, 1, 1'b0, 1);

      drive_pulse(1, 0, 0, 4);
      boundary(); wait_drain();
      expect_lit("glitch", 0, 0, 0, 1'b1, 2);
      boundary(); wait_drain();
      expect_lit("after_glitch", 0, 0, 0, 1'b0, 3);

      drive_pulse(300, 0, 0, 6);
      boundary(); wait_drain();
      expect_lit("stuck", 0, 0, 0, 1'b1, 4);

      repeat (20) drive_pulse(3, 0, 0, 3);
      boundary(); wait_drain();
      expect_lit("saturate", 20, 0, 15, 1'b0, 5);

      // pulse straddling a boundary belongs to the channel in which it ends
      for (int unsigned i = 0; i <= 10; i++) begin
         @(negedge aclk);
         lower_threshold = (i < 10);
         if (i == 4) begin
            channel = 1'b1;
            push_boundary();
         end
         if (i == 6) channel = 1'b0;
      end
      classify(10, 1'b0);
      repeat (4) @(negedge aclk) lower_threshold = 1'b0;
      wait_drain();
      expect_lit("inflight_first", 0, 0, 0, 1'b0, 6);
      boundary(); wait_drain();
      expect_lit("inflight_second", 1, 0, 1, 1'b0, 7);

      drive_pulse(5, 5, 1, 4);
      stray_upper();
      boundary(); wait_drain();
      expect_lit("fall_upper_stray", 0, 1, 0, 1'b1, 8);

      for (int c = 0; c < 25; c++) begin
         np = $urandom_range(0, 12);
         for (int unsigned p = 0; p < np; p++) begin
            w    = ($urandom_range(0, 9) == 0) ? 1 : $urandom_range(2, 12);
            kind = $urandom_range(0, 9);
            if (kind == 0) stray_upper();
            if (w >= 2 && kind < 4) begin
               int unsigned uo;
               uo = $urandom_range(1, w - 1);
               drive_pulse(w, uo, $urandom_range(1, w - uo), $urandom_range(3, 6));
            end else if (w >= 2 && kind == 4) begin
               drive_pulse(w, w, 1, $urandom_range(3, 6));
            end else begin
               drive_pulse(w, 0, 0, $urandom_range(3, 6));
            end
         end
         boundary();
      end
      wait_drain();

      repeat (2) drive_pulse(3, 0, 0, 4);
      @(negedge aclk) lower_threshold = 1'b1;
      repeat (2) @(negedge aclk);
      do_reset(3);
      repeat (4) @(negedge aclk);
      boundary(); wait_drain();
      expect_lit("after_reset", 0, 0, 0, 1'b0, 0);

      do_reset(0);
      repeat (4097) boundary();
      wait_drain();
      expect_lit("wrap_zero", 0, 0, 0, 1'b0, 0);
      boundary(); wait_drain();
      expect_lit("wrap_one", 0, 0, 0, 1'b0, 1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
